matrix_frame_arbiter: RTL and testbench



---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_scan_timer.sv | 40 ++++
 rtl/matrix_frame_arbiter.sv | 116 +++++++++++
 tb/tb_matrix_frame_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants and the arbitration state type for the
// 8x8 LED matrix frame arbiter and its scan timer.
package matrix_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;
  localparam int ROW_W    = 3;
  localparam int FRAME_W  = 64;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer: row-scan timebase for the LED matrix.
// A free-running SCAN_DIV-bit prescaler produces a one-cycle row_tick every
// 2^SCAN_DIV cycles; the row counter advances on each tick and wraps 7->0.
// frame_start marks the tick that performs the 7->0 wrap.
// Ports:
//   CLK         in   system clock
//   RESET       in   synchronous active-high reset
//   row_tick    out  one-cycle pulse per row step
//   row_idx     out  row currently being scanned
//   frame_start out  pulse coincident with the row 7->0 step
module matrix_scan_timer
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             row_tick,
  output logic [ROW_W-1:0] row_idx,
  output logic             frame_start
);

  logic [SCAN_DIV-1:0] prescale;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prescale <= '0;
      row_idx  <= '0;
    end else begin
      prescale <= prescale + SCAN_DIV'(1);
      if (row_tick) row_idx <= row_idx + ROW_W'(1);
    end
  end

  // Decoded from registered state, so the tick lands exactly in the
  // cycle the prescaler reads all-ones.
  assign row_tick    = &prescale;
  assign frame_start = row_tick && (row_idx == ROW_W'(NUM_ROWS - 1));

endmodule

// File: rtl/matrix_frame_arbiter.sv
// matrix_frame_arbiter: shares the 8x8 LED matrix scan driver between two
// 64-bit frame sources. A new frame is swapped in only at a frame boundary
// (row 7->0), so the displayed image is never torn. Contention is resolved
// round-robin, or fixed priority to source 0 when MATRIX_ARB_FIXED_PRIO_EN
// is defined.
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   req0_valid/data/ready   source 0 frame handshake
//   req1_valid/data/ready   source 1 frame handshake
//   frame_data              currently displayed frame (bit 8*r+c = row r, col c)
//   row_idx, row_tick       scan row and its update enable
//   frame_start             pulse on the row 7->0 step
//   grant_id                source of the displayed frame
//   blank                   high until the first frame is loaded
//
// state | meaning
// SCAN  | displaying, waiting for the frame-boundary tick
// GRANT | one cycle: sample valids and pick a source
// LOAD  | one cycle: ready to the chosen source, capture if still valid
module matrix_frame_arbiter
  import matrix_pkg::*;
#(
  parameter int NUM_BITS = 64,
  parameter int SCAN_DIV = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                req0_valid,
  input  logic [NUM_BITS-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [NUM_BITS-1:0] req1_data,
  output logic                req1_ready,
  output logic [NUM_BITS-1:0] frame_data,
  output logic [ROW_W-1:0]    row_idx,
  output logic                row_tick,
  output logic                frame_start,
  output logic                grant_id,
  output logic                blank
);

  if (NUM_BITS != FRAME_W || FRAME_W != NUM_ROWS * NUM_COLS) begin : g_width_err
    $error("matrix_frame_arbiter: NUM_BITS must be 64 (8 rows x 8 columns)");
  end
  if (SCAN_DIV < 1 || SCAN_DIV > 24) begin : g_div_err
    $error("matrix_frame_arbiter: SCAN_DIV must be within 1..24");
  end

  arb_state_t state, state_nxt;
  logic       sel, sel_nxt;
  logic       last_grant;
  logic       load_en;

  matrix_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .row_tick    (row_tick),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      SCAN: begin
        if (frame_start) state_nxt = GRANT;
      end
      GRANT: begin
        if (req0_valid || req1_valid) begin
          state_nxt = LOAD;
          if (req0_valid && req1_valid) begin
`ifdef MATRIX_ARB_FIXED_PRIO_EN
            sel_nxt = 1'b0;
`else
            sel_nxt = ~last_grant;
`endif
          end else begin
            sel_nxt = req1_valid;
          end
        end else begin
          state_nxt = SCAN;
        end
      end
      LOAD:    state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // Ready is masked by RESET so a reset landing in LOAD aborts the transfer
  // instead of completing a handshake the frame register will not keep.
  assign req0_ready = (state == LOAD) && !sel && !RESET;
  assign req1_ready = (state == LOAD) &&  sel && !RESET;
  assign load_en    = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= SCAN;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      frame_data <= '0;
      grant_id   <= 1'b0;
      blank      <= 1'b1;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (load_en) begin
        frame_data <= sel ? req1_data : req0_data;
        grant_id   <= sel;
        last_grant <= sel;
        blank      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_arbiter.sv
// Bench for matrix_frame_arbiter with SCAN_DIV=2: a row step every 4 cycles,
// a frame every 32 cycles. Cycle k counts from the first cycle after reset
// release; boundary tick at k%32==31, GRANT at k%32==0, LOAD at k%32==1.
module tb_matrix_frame_arbiter;

  localparam int NB = 64;
  localparam int SD = 2;

  logic          CLK;
  logic          RESET;
  logic          req0_valid, req1_valid;
  logic [NB-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [NB-1:0] frame_data;
  logic [2:0]    row_idx;
  logic          row_tick, frame_start, grant_id, blank;

  matrix_frame_arbiter #(.NUM_BITS(NB), .SCAN_DIV(SD)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .frame_data  (frame_data),
    .row_idx     (row_idx),
    .row_tick    (row_tick),
    .frame_start (frame_start),
    .grant_id    (grant_id),
    .blank       (blank)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit            src;
    logic [NB-1:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    k = 0;
  bit    in_rst = 1'b1;

  // Reference model: what the display should hold, by the arbitration rules.
  bit            m_last;
  logic [NB-1:0] m_frame;
  bit            m_gid;
  bit            m_blank;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_frame = '0;
    m_gid   = 1'b0;
    m_blank = 1'b1;
  endtask

  // Monitor: scan timing, ready legality, and transfers popped from the queue.
  always @(negedge CLK) begin : mon
    xfer_t e;
    if (!in_rst) begin
      check("row_tick", row_tick, (k % 4) == 3);
      check("row_idx", row_idx, (k / 4) % 8);
      check("frame_start", frame_start, (k % 32) == 31);
      check("ready_both", req0_ready && req1_ready, 0);
      if ((k % 32) != 1 || k < 32) check("ready_window", req0_ready || req1_ready, 0);
      if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer at k=%0d: got src %0d, expected none", k, req1_ready);
        end else begin
          e = exp_q.pop_front();
          check("xfer_src", req1_ready, e.src);
          check("xfer_data", req1_ready ? req1_data : req0_data, e.data);
        end
      end
    end
  end

  // Offer frames for one boundary; optionally drop the winner's valid in LOAD.
  task automatic run_frame(input bit v0, input bit v1, input logic [NB-1:0] d0,
                           input logic [NB-1:0] d1, input bit drop);
    bit has_w;
    bit w;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    has_w = v0 || v1;
    if (v0 && v1) begin
`ifdef MATRIX_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = !m_last;
`endif
    end else begin
      w = v1;
    end
    if (has_w && !drop) begin
      exp_q.push_back('{src: w, data: (w ? d1 : d0)});
      m_last  = w;
      m_frame = w ? d1 : d0;
      m_gid   = w;
      m_blank = 1'b0;
    end
    do step(); while (!(k >= 32 && (k % 32) == 1));
    if (drop && has_w) begin
      if (w) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
    end
    step();
    check("frame_data", frame_data, m_frame);
    check("grant_id", grant_id, m_gid);
    check("blank", blank, m_blank);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic reset_in_load();
    req0_valid = 1'b1;
    req0_data  = 64'hFF;
    req1_valid = 1'b0;
    do step(); while (!(k >= 32 && (k % 32) == 1));
    check("ready_in_load", req0_ready, 1);
    RESET  = 1'b1;
    in_rst = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_ready", req0_ready, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_blank", blank, 1);
    check("rst_row_idx", row_idx, 0);
    RESET      = 1'b0;
    req0_valid = 1'b0;
    k          = 0;
    model_reset();
    in_rst     = 1'b0;
  endtask

  initial begin
    RESET      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RESET  = 1'b0;
    k      = 0;
    in_rst = 1'b0;
    check("init_frame_data", frame_data, 0);
    check("init_blank", blank, 1);
    check("init_grant_id", grant_id, 0);
    check("init_row_idx", row_idx, 0);

    // Idle frames, then a held source 0 frame reloaded every boundary.
    run_frame(0, 0, '0, '0, 0);
    run_frame(0, 0, '0, '0, 0);
    run_frame(1, 0, 64'hA5A5_A5A5_A5A5_A5A5, '0, 0);
    run_frame(1, 0, 64'hA5A5_A5A5_A5A5_A5A5, '0, 0);
    // Continuous contention.
    for (int i = 0; i < 4; i++) run_frame(1, 1, 64'h1, 64'h2, 0);
    // Winner withdraws in LOAD; it must still win the next contention.
    run_frame(1, 1, 64'h1, 64'h2, 0);
    run_frame(1, 1, 64'h11, 64'h22, 1);
    run_frame(1, 1, 64'h33, 64'h44, 0);
    // Randomized frames.
    for (int i = 0; i < 10; i++)
      run_frame($urandom_range(0, 1), $urandom_range(0, 1),
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) == 0);

    reset_in_load();
    check("post_rst_blank", blank, 1);
    run_frame(1, 1, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 0);
    for (int i = 0; i < 3; i++)
      run_frame($urandom_range(0, 1), $urandom_range(0, 1),
                {$urandom, $urandom}, {$urandom, $urandom}, 0);

    repeat (2) step();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
